mod_counter_p: RTL

Parametrised modulo counter, the successor to the fixed 4-bit 0..11 counter. Adds:
- configurable width and modulus
- up/down direction
- synchronous load and clear
- wrap or saturate mode
- an integrated prescaler
- a cascadable terminal-count output

Sits in the timing/sequencing layer and drives display digits, clock dividers and multi-digit cascades (tc of one stage feeds en of the next).

---
 rtl/mod_counter_p_pkg.sv | 20 ++
 rtl/mod_counter_p_if.sv | 16 +
 rtl/mod_counter_p_prescaler_tick.sv | 27 ++
 rtl/mod_counter_p.sv | 66 ++++++
 4 files changed

// File: rtl/mod_counter_p_pkg.sv
// Shared constants and helpers for the modulo counter family.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold values 0..v-1; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v > 0 && ((v - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_counter_p_if.sv
// Control/status bundle between a counter stage and whatever drives it.
interface mod_counter_p_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrapped;

    modport master (output en, up, clr, load, load_val, input q, tc, wrapped);
    modport slave  (input en, up, clr, load, load_val, output q, tc, wrapped);
endinterface

// File: rtl/mod_counter_p_prescaler_tick.sv
// Enable-gated prescaler: tick fires on every PRESCALE-th enabled cycle.
module prescaler_tick
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : int'(clog2(PRESCALE));
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || sync_clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end
endmodule

// File: rtl/mod_counter_p.sv
// Parametrised up/down modulo counter with prescaler, wrap/saturate and cascadable tc.
module mod_counter_p
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 12,
    parameter int     PRESCALE = 1,
    parameter int     SATURATE = MODE_WRAP
) (
    input  logic           clk,
    input  logic           rst,
    mod_counter_p_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam bit               SAT     = (SATURATE == MODE_SAT);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mod_counter_p: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
        $error("mod_counter_p: MODULUS must be 2..2**WIDTH");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("mod_counter_p: PRESCALE must be 1..65535");
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
        $error("mod_counter_p: SATURATE must be 0 or 1");
    end

    logic [WIDTH-1:0] q_r;
    logic             wr_r;
    logic             tick;
    logic             at_bound;

    prescaler_tick #(.PRESCALE(PRESCALE)) u_pre (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .sync_clr (bus.clr | bus.load),
        .tick     (tick)
    );

    assign at_bound = (bus.up == DIR_UP) ? (q_r == MAX_Q) : (q_r == '0);

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            q_r  <= '0;
            wr_r <= 1'b0;
        end else if (bus.load) begin
            q_r <= ({1'b0, bus.load_val} >= MOD_EXT) ? MAX_Q : bus.load_val;
        end else if (tick) begin
            if (at_bound) begin
                wr_r <= 1'b1;
                if (!SAT) q_r <= (bus.up == DIR_UP) ? '0 : MAX_Q;
            end else begin
                q_r <= (bus.up == DIR_UP) ? q_r + WIDTH'(1) : q_r - WIDTH'(1);
            end
        end
    end

    assign bus.q       = q_r;
    assign bus.wrapped = wr_r;
    // Combinational so a downstream stage enabled by tc steps on the same edge.
    assign bus.tc      = tick & at_bound & ~bus.load & ~bus.clr & ~rst;
endmodule
